// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, response and ALU signal bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
   parameter int NREQ       = 2,
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 12
);
   logic [NREQ-1:0]            req_valid;
   logic [NREQ-1:0]            req_ready;
   logic [NREQ*DATA_WIDTH-1:0] req_a;
   logic [NREQ*DATA_WIDTH-1:0] req_b;
   logic [NREQ*OP_WIDTH-1:0]   req_op;
   logic [NREQ-1:0]            rsp_valid;
   logic [NREQ-1:0]            rsp_ready;
   logic [DATA_WIDTH-1:0]      rsp_result;
   logic                       rsp_zero;
   logic                       rsp_overflow;
   logic                       rsp_carryout;
   logic                       rsp_err;
   logic [DATA_WIDTH-1:0]      alu_a;
   logic [DATA_WIDTH-1:0]      alu_b;
   logic [OP_WIDTH-1:0]        alu_op;
   logic [DATA_WIDTH-1:0]      alu_result;
   logic                       alu_zero;
   logic                       alu_overflow;
   logic                       alu_carryout;

   // Arbiter side
   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
             alu_result, alu_zero, alu_overflow, alu_carryout,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
             rsp_carryout, rsp_err, alu_a, alu_b, alu_op
   );

   // Requesters plus the ALU itself
   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
             alu_result, alu_zero, alu_overflow, alu_carryout,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_overflow,
             rsp_carryout, rsp_err, alu_a, alu_b, alu_op
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between requesters
module alu_share_arbiter #(
   parameter int NREQ       = 2,
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 12
) (
   input  logic                 clk,
   input  logic                 resetn,
   alu_share_arbiter_if.slave   bus
);
   localparam int IDX_W = (NREQ > 2) ? 2 : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   logic [1:0]            state;
   logic [IDX_W-1:0]      gnt;
   logic [IDX_W-1:0]      rr_last;
   logic [IDX_W-1:0]      win;
   logic                  any_valid;
   int                    srch;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [OP_WIDTH-1:0]   op_q;
   logic                  op_ok;
   logic [DATA_WIDTH-1:0] res_q;
   logic                  zero_q;
   logic                  ovf_q;
   logic                  cy_q;
   logic                  err_q;

   // Round-robin winner: scan offsets from far to near so the nearest valid index after rr_last wins
   always_comb begin
      win       = '0;
      any_valid = 1'b0;
      srch      = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         srch = (int'(rr_last) + 1 + k) % NREQ;
         if (bus.req_valid[srch]) begin
            win       = IDX_W'(srch);
            any_valid = 1'b1;
         end
      end
   end

   // Opcode must have exactly one bit set to reach the ALU
   assign op_ok = (op_q != '0) && ((op_q & (op_q - 1'b1)) == '0);

   // Handshake outputs are pure decodes of state, so reset clears them immediately
   always_comb begin
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      if (state == ST_IDLE && any_valid) begin
         bus.req_ready[win] = 1'b1;
      end
      if (state == ST_RESP) begin
         bus.rsp_valid[gnt] = 1'b1;
      end
   end

   assign bus.alu_a        = a_q;
   assign bus.alu_b        = b_q;
   assign bus.alu_op       = (state == ST_ISSUE && op_ok) ? op_q : '0;
   assign bus.rsp_result   = res_q;
   assign bus.rsp_zero     = zero_q;
   assign bus.rsp_overflow = ovf_q;
   assign bus.rsp_carryout = cy_q;
   assign bus.rsp_err      = err_q;

   // IDLE -> ISSUE -> RESP sequencer with operand latch and result capture
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ST_IDLE;
         gnt     <= '0;
         rr_last <= IDX_W'(NREQ - 1);
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cy_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  a_q     <= bus.req_a[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                  b_q     <= bus.req_b[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                  op_q    <= bus.req_op[int'(win)*OP_WIDTH +: OP_WIDTH];
                  gnt     <= win;
                  rr_last <= win;
                  state   <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               err_q <= !op_ok;
               if (op_ok) begin
                  res_q  <= bus.alu_result;
                  zero_q <= bus.alu_zero;
                  ovf_q  <= bus.alu_overflow;
                  cy_q   <= bus.alu_carryout;
               end else begin
                  res_q  <= '0;
                  zero_q <= 1'b0;
                  ovf_q  <= 1'b0;
                  cy_q   <= 1'b0;
               end
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready[gnt]) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
   localparam int NREQ = 2;
   localparam int DW   = 32;
   localparam int OW   = 12;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [DW:0]   alu_sum;
   logic [DW-1:0] alu_res;
   logic          alu_ovf;
   logic          alu_cy;
   logic [OW-1:0] ill_ops [2];

   always #5 clk = ~clk;

   alu_share_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

   alu_share_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Reference ALU for the opcodes the bench uses
   always_comb begin
      alu_sum = '0;
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_cy  = 1'b0;
      case (bus.alu_op)
         12'h001: begin
            alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            alu_res = alu_sum[DW-1:0];
            alu_cy  = alu_sum[DW];
            alu_ovf = (bus.alu_a[DW-1] == bus.alu_b[DW-1]) && (alu_res[DW-1] != bus.alu_a[DW-1]);
         end
         12'h002: begin
            alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            alu_res = alu_sum[DW-1:0];
            alu_cy  = alu_sum[DW];
            alu_ovf = (bus.alu_a[DW-1] != bus.alu_b[DW-1]) && (alu_res[DW-1] != bus.alu_a[DW-1]);
         end
         12'h004: alu_res = bus.alu_a & bus.alu_b;
         12'h008: alu_res = bus.alu_a | bus.alu_b;
         12'h080: alu_res = {{(DW-1){1'b0}}, (bus.alu_a < bus.alu_b)};
         default: alu_res = '0;
      endcase
   end

   assign bus.alu_result   = alu_res;
   assign bus.alu_zero     = (alu_res == '0);
   assign bus.alu_overflow = alu_ovf;
   assign bus.alu_carryout = alu_cy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
      bus.req_a[i*DW +: DW]  = a;
      bus.req_b[i*DW +: DW]  = b;
      bus.req_op[i*OW +: OW] = op;
      bus.req_valid[i]       = 1'b1;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = '0;
      ill_ops[0]    = 12'h003;
      ill_ops[1]    = 12'h000;

      // reset values
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst rsp_valid", bus.rsp_valid, 2'b00);
      check("rst req_ready", bus.req_ready, 2'b00);
      check("rst alu_op", bus.alu_op, 12'h000);
      check("rst result", bus.rsp_result, 32'h0);
      check("rst err", bus.rsp_err, 1'b0);
      check("rst alu_a", bus.alu_a, 32'h0);
      @(negedge clk);
      resetn = 1'b1;

      // 1: single add
      set_req(0, 32'd5, 32'd7, 12'h001);
      #1 check("t1 ready", bus.req_ready, 2'b01);
      tick;
      bus.req_valid = '0;
      #1;
      check("t1 alu_op", bus.alu_op, 12'h001);
      check("t1 alu_a", bus.alu_a, 32'd5);
      check("t1 alu_b", bus.alu_b, 32'd7);
      check("t1 ready issue", bus.req_ready, 2'b00);
      check("t1 no rsp yet", bus.rsp_valid, 2'b00);
      tick;
      check("t1 rsp_valid", bus.rsp_valid, 2'b01);
      check("t1 result", bus.rsp_result, 32'd12);
      check("t1 zero", bus.rsp_zero, 1'b0);
      check("t1 ovf", bus.rsp_overflow, 1'b0);
      check("t1 err", bus.rsp_err, 1'b0);
      check("t1 alu_op resp", bus.alu_op, 12'h000);
      bus.rsp_ready = 2'b01;
      tick;
      check("t1 rsp drop", bus.rsp_valid, 2'b00);
      bus.rsp_ready = 2'b00;

      // 2: contention straight after reset
      resetn = 1'b0;
      tick;
      resetn = 1'b1;
      set_req(0, 32'd3, 32'd3, 12'h002);
      set_req(1, 32'hF0, 32'h0F, 12'h008);
      bus.rsp_ready = 2'b11;
      #1 check("t2 ready r0", bus.req_ready, 2'b01);
      tick;
      check("t2 ready issue", bus.req_ready, 2'b00);
      tick;
      check("t2 rsp r0", bus.rsp_valid, 2'b01);
      check("t2 result r0", bus.rsp_result, 32'h0);
      check("t2 zero r0", bus.rsp_zero, 1'b1);
      set_req(0, 32'hFF, 32'h0F, 12'h004);
      tick;
      check("t2 ready r1", bus.req_ready, 2'b10);
      tick;
      bus.req_valid[1] = 1'b0;
      tick;
      check("t2 rsp r1", bus.rsp_valid, 2'b10);
      check("t2 result r1", bus.rsp_result, 32'hFF);
      check("t2 zero r1", bus.rsp_zero, 1'b0);
      tick;
      check("t2 ready r0 again", bus.req_ready, 2'b01);
      tick;
      bus.req_valid[0] = 1'b0;
      tick;
      check("t2 rsp r0 again", bus.rsp_valid, 2'b01);
      check("t2 result r0 again", bus.rsp_result, 32'h0F);
      tick;
      check("t2 idle", bus.rsp_valid, 2'b00);
      bus.rsp_ready = 2'b00;

      // 3: backpressure on requester 1, ready on the wrong index ignored
      bus.rsp_ready = 2'b01;
      set_req(1, 32'h7FFFFFFF, 32'h1, 12'h001);
      #1 check("t3 ready", bus.req_ready, 2'b10);
      tick;
      bus.req_valid = '0;
      tick;
      for (int k = 0; k < 5; k++) begin
         check("t3 hold valid", bus.rsp_valid, 2'b10);
         check("t3 hold result", bus.rsp_result, 32'h80000000);
         check("t3 hold ovf", bus.rsp_overflow, 1'b1);
         check("t3 hold zero", bus.rsp_zero, 1'b0);
         check("t3 hold ready", bus.req_ready, 2'b00);
         if (k < 4) tick;
      end
      bus.rsp_ready = 2'b10;
      tick;
      check("t3 release", bus.rsp_valid, 2'b00);
      bus.rsp_ready = 2'b00;

      // 4: opcodes that are not one-hot
      for (int k = 0; k < 2; k++) begin
         set_req(0, 32'd5, 32'd7, ill_ops[k]);
         #1 check("t4 ready", bus.req_ready, 2'b01);
         tick;
         bus.req_valid = '0;
         check("t4 alu_op gated", bus.alu_op, 12'h000);
         check("t4 alu_a", bus.alu_a, 32'd5);
         tick;
         check("t4 rsp_valid", bus.rsp_valid, 2'b01);
         check("t4 err", bus.rsp_err, 1'b1);
         check("t4 result", bus.rsp_result, 32'h0);
         check("t4 zero", bus.rsp_zero, 1'b0);
         check("t4 ovf", bus.rsp_overflow, 1'b0);
         check("t4 cy", bus.rsp_carryout, 1'b0);
         bus.rsp_ready = 2'b01;
         tick;
         bus.rsp_ready = 2'b00;
      end

      // 5: reset while a response is pending
      set_req(0, 32'd1, 32'd1, 12'h001);
      tick;
      bus.req_valid = '0;
      tick;
      check("t5 rsp before rst", bus.rsp_valid, 2'b01);
      check("t5 result before rst", bus.rsp_result, 32'd2);
      check("t5 err cleared", bus.rsp_err, 1'b0);
      #2 resetn = 1'b0;
      #1;
      check("t5 rst rsp_valid", bus.rsp_valid, 2'b00);
      check("t5 rst result", bus.rsp_result, 32'h0);
      check("t5 rst alu_a", bus.alu_a, 32'h0);
      bus.rsp_ready = 2'b01;
      @(negedge clk);
      resetn = 1'b1;
      tick;
      check("t5 no stale rsp", bus.rsp_valid, 2'b00);
      bus.rsp_ready = 2'b00;
      set_req(1, 32'd1, 32'd2, 12'h080);
      #1 check("t5 ready r1", bus.req_ready, 2'b10);
      tick;
      bus.req_valid = '0;
      check("t5 alu_op", bus.alu_op, 12'h080);
      tick;
      check("t5 rsp r1", bus.rsp_valid, 2'b10);
      check("t5 result", bus.rsp_result, 32'd1);
      bus.rsp_ready = 2'b10;
      tick;
      check("t5 done", bus.rsp_valid, 2'b00);
      bus.rsp_ready = 2'b00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU (12-bit one-hot ALUop; flags Zero, Overflow, CarryOut) between NREQ requesters, e.g. the multi-cycle CPU main datapath and the branch/address unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers operands, drives the ALU for one cycle, captures the result and flags, and holds them until the requester accepts.
- Only one operation is in flight at a time.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DATA_WIDTH, 32, operand/result width.
- OP_WIDTH, 12, ALU one-hot opcode width. Bit order: add, sub, and, or, nor, xor, slt, sltu, sll, srl, sra, lui.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept (combinational).
- req_a  in  NREQ*DATA_WIDTH  packed A operands; requester i uses slice i.
- req_b  in  NREQ*DATA_WIDTH  packed B operands.
- req_op  in  NREQ*OP_WIDTH  packed one-hot opcodes.
- rsp_valid  out  NREQ  response valid; at most one bit set.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_result  out  DATA_WIDTH  captured ALU Result.
- rsp_zero  out  1  captured Zero.
- rsp_overflow  out  1  captured Overflow.
- rsp_carryout  out  1  captured CarryOut.
- rsp_err  out  1  opcode was not one-hot.
- alu_a  out  DATA_WIDTH  to ALU A.
- alu_b  out  DATA_WIDTH  to ALU B.
- alu_op  out  OP_WIDTH  to ALUop.
- alu_result  in  DATA_WIDTH  from ALU Result.
- alu_zero  in  1  from ALU Zero.
- alu_overflow  in  1  from ALU Overflow.
- alu_carryout  in  1  from ALU CarryOut.

Behaviour:
- State machine with three states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values:
  - rsp_valid=0, rsp_result=0, all rsp flags=0, rsp_err=0.
  - Operand registers=0, alu_op=0, grant index=0.
  - Round-robin pointer rr_last=NREQ-1, so requester 0 has first priority.
- IDLE:
  - Winner g is the first index with req_valid set, searching from (rr_last+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally; all other req_ready bits=0.
  - On the handshake: latch req_a[g], req_b[g], req_op[g] and g; set rr_last=g; go to ISSUE.
  - If no req_valid bit is set: stay in IDLE, no pointer change.
- ISSUE (exactly 1 cycle):
  - alu_a/alu_b = latched operands.
  - alu_op = latched op if it is one-hot, else 0.
  - At the end of the cycle, capture alu_result, alu_zero, alu_overflow and alu_carryout into the rsp registers.
  - rsp_err = not one-hot. When rsp_err=1: result and all flags are forced to 0, including zero.
  - Go to RESP.
- RESP:
  - rsp_valid[g]=1; rsp outputs held stable.
  - On rsp_ready[g]=1: go to IDLE and deassert rsp_valid next cycle.
  - rsp_ready on other indices is ignored.
- alu_op=0 in every state except ISSUE; alu_a/alu_b keep the latched values.
- req_ready=0 in ISSUE and RESP.
- Latency: handshake in cycle T → rsp_valid at T+2. Next accept at T+3 at the earliest. Peak throughput is 1 op per 3 cycles.
- Backpressure: RESP is held indefinitely. The response must not change while rsp_valid=1 and rsp_ready=0.
- Requests do not need to stay valid after acceptance. Changing an unaccepted request's operands has no effect until it is granted.
- Fairness: a requester that stays continuously valid is granted within NREQ grants.
- Reset asserted mid-operation (ISSUE or RESP):
  - The in-flight op is discarded; all outputs return to reset values immediately (asynchronously).
  - No response is ever issued for the discarded op.

Test Plan:
1. Single add: req0 A=5, B=7, op=0x001 → req_ready[0]=1 in that cycle; alu_op=0x001 one cycle later; rsp_valid=01 two cycles after accept with result=12, zero=0, overflow=0.
2. Simultaneous contention after reset: req0 sub 3-3 (op=0x002), req1 or 0xF0|0x0F (op=0x008), both held valid → req0 served first (result=0, zero=1); req1 next (result=0xFF); a second req0 is served after req1.
3. Backpressure: req1 add 0x7FFFFFFF+1 with rsp_ready=0 for 5 cycles → rsp_valid=10 held all 5 cycles; result=0x80000000 and overflow=1 stable; req_ready=00 throughout; both deassert one cycle after rsp_ready[1]=1.
4. Illegal opcode: req0 op=0x003 (and again with op=0x000) → alu_op stays 0 during ISSUE; rsp_err=1, result=0, all flags=0.
5. Reset during RESP: resetn=0 while rsp_valid=01 → rsp_valid=00 and result=0 immediately. After release, a req1 sltu 1<2 (op=0x080) is granted first (rr_last=NREQ-1 → index 0 is searched first, req0 is idle) and returns result=1.
